// File: rtl/boot_pkg.sv
// Shared types and constants for the SPI boot loader (spi_boot_ctrl, byte_packer).
// Build option SPI_BOOT_CHECKSUM_EN enables the trailer checksum byte.
package boot_pkg;

  localparam logic [7:0] BOOT_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    WAIT_MAGIC,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    RUN,
    ERROR
  } boot_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_CSUM    = 2'd3
  } boot_err_t;

  // States in which the inter-byte idle timeout is armed.
  function automatic logic in_frame(input boot_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/spi_boot_ctrl_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream; first byte lands in [7:0].
// word_valid_o is combinational and coincides with the lane-3 byte.
module byte_packer (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  byte_i,
  input  logic        valid_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  lane_q;
  logic [31:0] data_q;

  assign word_o       = {byte_i, data_q[31:8]};
  assign word_valid_o = valid_i && !clear_i && (lane_q == 2'd3);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lane_q <= 2'd0;
      data_q <= 32'd0;
    end else if (clear_i) begin
      lane_q <= 2'd0;
      data_q <= 32'd0;
    end else if (valid_i) begin
      lane_q <= lane_q + 2'd1;
      data_q <= {byte_i, data_q[31:8]};
    end
  end

endmodule

// File: rtl/spi_boot_ctrl.sv
// SPI boot sequencer: holds the CPU in reset, loads a framed image into RAM, then releases it.
// Define SPI_BOOT_CHECKSUM_EN to require an XOR trailer byte after the payload.
module spi_boot_ctrl
  import boot_pkg::*;
#(
  parameter int DEPTH_WORDS    = 256,
  parameter int AW             = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [7:0]    spi_data,
  input  logic          spi_valid,
  output logic          cpu_resetn,
  output logic          ram_owner,
  output logic          ld_we,
  output logic [AW-1:0] ld_addr,
  output logic [31:0]   ld_wdata,
  output logic          busy,
  output logic [1:0]    err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] MAX_LEN = 16'(DEPTH_WORDS);

  boot_state_t   state_q;
  boot_err_t     err_q;
  logic          cpu_resetn_q;
  logic          busy_q;
  logic          ld_we_q;
  logic [AW-1:0] ld_addr_q;
  logic [31:0]   ld_wdata_q;
  logic [7:0]    len_lo_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] last_q;
  logic [TW-1:0] idle_q;
`ifdef SPI_BOOT_CHECKSUM_EN
  logic [7:0]    csum_q;
`endif

  logic [15:0] len_d;
  logic        timeout_d;
  logic        magic_d;
  logic [31:0] word;
  logic        word_valid;

  assign len_d     = {spi_data, len_lo_q};
  assign magic_d   = spi_valid && (spi_data == BOOT_MAGIC);
  assign timeout_d = in_frame(state_q) && !spi_valid &&
                     (idle_q == TW'(TIMEOUT_CYCLES - 1));

  byte_packer u_packer (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .byte_i       (spi_data),
    .valid_i      (spi_valid && (state_q == DATA)),
    .clear_i      (state_q != DATA),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  assign cpu_resetn = cpu_resetn_q;
  assign ram_owner  = ~cpu_resetn_q;
  assign ld_we      = ld_we_q;
  assign ld_addr    = ld_addr_q;
  assign ld_wdata   = ld_wdata_q;
  assign busy       = busy_q;
  assign err        = err_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= WAIT_MAGIC;
      err_q        <= ERR_NONE;
      cpu_resetn_q <= 1'b0;
      busy_q       <= 1'b0;
      ld_we_q      <= 1'b0;
      ld_addr_q    <= '0;
      ld_wdata_q   <= 32'd0;
      len_lo_q     <= 8'd0;
      idx_q        <= '0;
      last_q       <= '0;
      idle_q       <= '0;
`ifdef SPI_BOOT_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      ld_we_q <= 1'b0;
      if (spi_valid || !in_frame(state_q)) idle_q <= '0;
      else                                 idle_q <= idle_q + TW'(1);

      if (timeout_d) begin
        state_q <= ERROR;
        err_q   <= ERR_TIMEOUT;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          WAIT_MAGIC, RUN, ERROR: begin
            // A data-path finish enters RUN with the CPU still held; it releases here one cycle later.
            if (state_q == RUN) cpu_resetn_q <= 1'b1;
            if (magic_d) begin
              state_q      <= LEN_LO;
              err_q        <= ERR_NONE;
              cpu_resetn_q <= 1'b0;
              busy_q       <= 1'b1;
`ifdef SPI_BOOT_CHECKSUM_EN
              csum_q       <= 8'd0;
`endif
            end
          end
          LEN_LO: begin
            if (spi_valid) begin
              len_lo_q <= spi_data;
              state_q  <= LEN_HI;
`ifdef SPI_BOOT_CHECKSUM_EN
              csum_q   <= csum_q ^ spi_data;
`endif
            end
          end
          LEN_HI: begin
            if (spi_valid) begin
`ifdef SPI_BOOT_CHECKSUM_EN
              csum_q <= csum_q ^ spi_data;
`endif
              if (len_d > MAX_LEN) begin
                state_q <= ERROR;
                err_q   <= ERR_LEN;
                busy_q  <= 1'b0;
              end else if (len_d == 16'd0) begin
`ifdef SPI_BOOT_CHECKSUM_EN
                state_q <= CSUM;
`else
                state_q      <= RUN;
                cpu_resetn_q <= 1'b1;
                busy_q       <= 1'b0;
`endif
              end else begin
                state_q <= DATA;
                idx_q   <= '0;
                last_q  <= AW'(len_d - 16'd1);
              end
            end
          end
          DATA: begin
            if (spi_valid) begin
`ifdef SPI_BOOT_CHECKSUM_EN
              csum_q <= csum_q ^ spi_data;
`endif
              if (word_valid) begin
                ld_we_q    <= 1'b1;
                ld_addr_q  <= idx_q;
                ld_wdata_q <= word;
                idx_q      <= idx_q + AW'(1);
                if (idx_q == last_q) begin
`ifdef SPI_BOOT_CHECKSUM_EN
                  state_q <= CSUM;
`else
                  state_q <= RUN;
                  busy_q  <= 1'b0;
`endif
                end
              end
            end
          end
`ifdef SPI_BOOT_CHECKSUM_EN
          CSUM: begin
            if (spi_valid) begin
              busy_q <= 1'b0;
              if (spi_data == csum_q) begin
                state_q      <= RUN;
                cpu_resetn_q <= 1'b1;
              end else begin
                state_q <= ERROR;
                err_q   <= ERR_CSUM;
              end
            end
          end
`endif
          default: begin
            state_q <= WAIT_MAGIC;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_boot_ctrl.sv
// Scoreboard bench for spi_boot_ctrl; expected RAM writes are queued, a monitor pops them.
// Adapts to SPI_BOOT_CHECKSUM_EN when the bench is built with it.
module tb_spi_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  spiData = 8'd0;
  logic        spiValid = 1'b0;
  logic        cpuResetn;
  logic        ramOwner;
  logic        ldWe;
  logic [7:0]  ldAddr;
  logic [31:0] ldWdata;
  logic        busy;
  logic [1:0]  err;

  int errors = 0;
  int checks = 0;
  logic [7:0]  tbCsum = 8'd0;
  logic [39:0] expQ[$];

  spi_boot_ctrl #(
    .DEPTH_WORDS    (256),
    .AW             (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .spi_data   (spiData),
    .spi_valid  (spiValid),
    .cpu_resetn (cpuResetn),
    .ram_owner  (ramOwner),
    .ld_we      (ldWe),
    .ld_addr    (ldAddr),
    .ld_wdata   (ldWdata),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && ldWe) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedWrite: got addr=%0d data=%h, required no write", ldAddr, ldWdata);
      end else begin
        logic [39:0] e;
        e = expQ.pop_front();
        if (ldAddr !== e[39:32] || ldWdata !== e[31:0]) begin
          errors++;
          $display("[TB] FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   ldAddr, ldWdata, e[39:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    spiData  = b;
    spiValid = 1'b1;
    @(negedge clk);
    spiValid = 1'b0;
  endtask

  task automatic startFrame();
    tbCsum = 8'd0;
    applyStimulus(8'hA5);
  endtask

  task automatic sendBody(input logic [7:0] b);
    tbCsum = tbCsum ^ b;
    applyStimulus(b);
  endtask

  task automatic expectWrite(input logic [7:0] a, input logic [31:0] d);
    expQ.push_back({a, d});
  endtask

  task automatic finishFrame(input string tag);
`ifdef SPI_BOOT_CHECKSUM_EN
    applyStimulus(tbCsum);
`else
    checkOutput({tag, "_heldOnWrite"}, {31'd0, cpuResetn}, 32'd0);
    @(negedge clk);
`endif
    checkOutput({tag, "_release"}, {31'd0, cpuResetn}, 32'd1);
    checkOutput({tag, "_ramOwner"}, {31'd0, ramOwner}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_err"}, {30'd0, err}, 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cpuResetn"}, {31'd0, cpuResetn}, 32'd0);
    checkOutput({tag, "_ramOwner"}, {31'd0, ramOwner}, 32'd1);
    checkOutput({tag, "_ldWe"}, {31'd0, ldWe}, 32'd0);
    checkOutput({tag, "_ldAddr"}, {24'd0, ldAddr}, 32'd0);
    checkOutput({tag, "_ldWdata"}, ldWdata, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_err"}, {30'd0, err}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("idle");

    // Valid two-word frame
    expectWrite(8'd0, 32'h44332211);
    expectWrite(8'd1, 32'h88776655);
    startFrame();
    checkOutput("magic_busy", {31'd0, busy}, 32'd1);
    checkOutput("magic_cpuResetn", {31'd0, cpuResetn}, 32'd0);
    sendBody(8'h02); sendBody(8'h00);
    sendBody(8'h11); sendBody(8'h22); sendBody(8'h33); sendBody(8'h44);
    sendBody(8'h55); sendBody(8'h66); sendBody(8'h77); sendBody(8'h88);
    finishFrame("valid");

    // Reload while running
    startFrame();
    checkOutput("reload_cpuResetn", {31'd0, cpuResetn}, 32'd0);
    checkOutput("reload_ramOwner", {31'd0, ramOwner}, 32'd1);
    expectWrite(8'd0, 32'hDDCCBBAA);
    sendBody(8'h01); sendBody(8'h00);
    sendBody(8'hAA); sendBody(8'hBB); sendBody(8'hCC); sendBody(8'hDD);
    finishFrame("reload");

    // Oversize length 257
    startFrame();
    sendBody(8'h01); sendBody(8'h01);
    checkOutput("oversize_err", {30'd0, err}, 32'd1);
    checkOutput("oversize_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("oversize_cpuResetn", {31'd0, cpuResetn}, 32'd0);

    // Timeout after one payload byte
    startFrame();
    sendBody(8'h01); sendBody(8'h00); sendBody(8'h11);
    repeat (15) @(negedge clk);
    checkOutput("timeout_notYet_err", {30'd0, err}, 32'd0);
    checkOutput("timeout_notYet_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("timeout_err", {30'd0, err}, 32'd2);
    checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
    checkOutput("timeout_cpuResetn", {31'd0, cpuResetn}, 32'd0);

    // Byte on the expiry cycle keeps the frame alive
    startFrame();
    checkOutput("rearm_err", {30'd0, err}, 32'd0);
    expectWrite(8'd0, 32'h44332211);
    sendBody(8'h01); sendBody(8'h00); sendBody(8'h11);
    repeat (15) @(negedge clk);
    sendBody(8'h22);
    checkOutput("alive_busy", {31'd0, busy}, 32'd1);
    checkOutput("alive_err", {30'd0, err}, 32'd0);
    sendBody(8'h33); sendBody(8'h44);
    finishFrame("alive");

    // Checksum mismatch (macro on) or plain release (macro off)
    startFrame();
    expectWrite(8'd0, 32'hEFBEADDE);
    sendBody(8'h01); sendBody(8'h00);
    sendBody(8'hDE); sendBody(8'hAD); sendBody(8'hBE); sendBody(8'hEF);
`ifdef SPI_BOOT_CHECKSUM_EN
    applyStimulus(8'h00);
    checkOutput("badcsum_err", {30'd0, err}, 32'd3);
    checkOutput("badcsum_cpuResetn", {31'd0, cpuResetn}, 32'd0);
    checkOutput("badcsum_busy", {31'd0, busy}, 32'd0);
`else
    finishFrame("nocsum");
`endif

    // Asynchronous reset after two payload bytes
    startFrame();
    sendBody(8'h02); sendBody(8'h00); sendBody(8'h11); sendBody(8'h22);
    rst = 1'b1;
    #1;
    checkResetValues("midReset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expectWrite(8'd0, 32'h04030201);
    startFrame();
    sendBody(8'h01); sendBody(8'h00);
    sendBody(8'h01); sendBody(8'h02); sendBody(8'h03); sendBody(8'h04);
    finishFrame("afterReset");

    repeat (3) @(negedge clk);
    checkOutput("pendingWrites", expQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
